pingpong_frame_scheduler: RTL and testbench
===========================================

// Module: pingpong_frame_scheduler
// PURPOSE
//  Sequences frame assembly on the AXI-Stream output path. Round-robin arbitrates whole frames
//  between two ping-pong payload sources, then appends META_LEN metadata beats and one frame-counter
//  beat (tlast). Owns config latching, a sequential words-per-frame divider and the frame counter.
// PARAMETERS
//  DW        128  stream data width (bits), multiple of 8
//  CNT_W     32   frame counter width, CNT_W <= DW
//  META_LEN  1    metadata beats per frame, >= 1
// PORTS
//  clk              in   1      clock
//  resetn           in   1      asynchronous active-low reset
//  enable           in   1      level; 1 = run frames, 0 = stop after current frame
//  cfg_load         in   1      pulse; latch cfg_frame_size/cfg_packet_size (honoured in IDLE only)
//  cfg_frame_size   in   32     frame size in bytes
//  cfg_packet_size  in   16     packet size in bytes (one payload beat per packet)
//  cfg_err          out  1      sticky: last cfg_load gave packet_size==0 or quotient==0
//  s0_tdata/tvalid/tready  in/in/out  DW/1/1  ping payload source
//  s1_tdata/tvalid/tready  in/in/out  DW/1/1  pong payload source
//  sm_tdata/tvalid/tready  in/in/out  DW/1/1  metadata source
//  m_tdata/tvalid/tready   out/out/in DW/1/1  assembled output stream
//  m_tlast          out  1      high on frame-counter beat only
//  m_tkeep          out  DW/8   all ones whenever m_tvalid
//  frame_count      out  CNT_W  frames completed (wraps at 2^CNT_W)
//  busy             out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, frame_count=0, cfg_err=0, nwords=0, last_grant=1 (s0 first),
//   all tready/m_tvalid/m_tlast=0, m_tdata=0. Reset mid-frame aborts frame; no tlast emitted.
//  FSM: IDLE, CALC, WAIT_SRC, DATA, META, COUNT.
//  IDLE: cfg_load -> latch cfg_*, CALC. enable=1 and nwords!=0 and cfg_err=0 -> WAIT_SRC.
//   cfg_load in any other state ignored.
//  CALC: 32-cycle restoring divide nwords=frame_size/packet_size (truncating), one quotient bit per
//   clk; exactly 33 cycles from cfg_load to IDLE. packet_size==0 -> skip divide, 1 cycle, cfg_err=1.
//   quotient==0 -> cfg_err=1, nwords=0. Valid result clears cfg_err.
//  WAIT_SRC: grant s0 if only s0_tvalid, s1 if only s1_tvalid; both -> source != last_grant.
//   Grant registered; DATA entered next cycle. enable=0 here -> IDLE.
//  DATA: m_* = granted source combinationally (zero latency); granted tready = m_tready, other=0.
//   Beat counter increments on m_tvalid&m_tready; after nwords-th beat -> META; last_grant=grant.
//  META: m_* = sm_*, sm_tready = m_tready; after META_LEN handshakes -> COUNT.
//  COUNT: m_tdata = zero-extended frame_count, m_tvalid=1, m_tlast=1. On handshake frame_count+1
//   (wrap to 0), -> WAIT_SRC if enable else IDLE.
//  enable falling mid-frame: frame completes fully. m_tvalid held with data stable until accepted.
//  sm_tready=0 outside META; s0/s1_tready=0 outside DATA. Beat counter width 32.
// TESTING
//  cfg 1024/64, enable, s0 always valid -> 16 s0 beats, 1 meta, counter=0 beat with tlast; count=1.
//  s0,s1 both valid 4 frames -> grant order s0,s1,s0,s1; counter beats 0,1,2,3.
//  random m_tready 30% low -> no beat lost/duplicated; data stable while tvalid&!tready.
//  cfg_packet_size=0 -> cfg_err=1 after 1 cycle, stays IDLE; cfg 100/64 -> nwords=1, cfg_err=0.
//  resetn low during DATA beat 5 -> outputs 0 same cycle; after release frame_count=0, busy=0.
//  preload frame_count=2^CNT_W-1 (CNT_W=4) -> counter beat 15, then frame_count=0.

Source files
------------

// File: rtl/pingpong_frame_scheduler.sv
// Frame scheduler: round-robin whole-frame arbitration between two ping-pong payload sources,
// followed by META_LEN metadata beats and a frame-counter beat carrying tlast.
module pingpong_frame_scheduler #(
   parameter int unsigned DW       = 128,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned META_LEN = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic             cfg_load,
   input  logic [31:0]      cfg_frame_size,
   input  logic [15:0]      cfg_packet_size,
   output logic             cfg_err,
   input  logic [DW-1:0]    s0_tdata,
   input  logic             s0_tvalid,
   output logic             s0_tready,
   input  logic [DW-1:0]    s1_tdata,
   input  logic             s1_tvalid,
   output logic             s1_tready,
   input  logic [DW-1:0]    sm_tdata,
   input  logic             sm_tvalid,
   output logic             sm_tready,
   output logic [DW-1:0]    m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   output logic [DW/8-1:0]  m_tkeep,
   output logic [CNT_W-1:0] frame_count,
   output logic             busy
);

   localparam int unsigned KW        = DW / 8;
   localparam int unsigned FS_W      = 32;
   localparam int unsigned PS_W      = 16;
   localparam int unsigned BEAT_W    = 32;
   localparam int unsigned DIV_STEPS = 32;
   localparam int unsigned DCNT_W    = 5;
   localparam int unsigned META_W    = (META_LEN > 1) ? $clog2(META_LEN) : 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CALC     = 3'd1,
      WAIT_SRC = 3'd2,
      DATA     = 3'd3,
      META     = 3'd4,
      COUNT    = 3'd5
   } state_t;

   state_t              state, state_nxt;
   logic [PS_W-1:0]     packet_size_q;
   logic [FS_W-1:0]     div_q;
   logic [PS_W-1:0]     rem_q;
   logic [DCNT_W-1:0]   div_cnt;
   logic [BEAT_W-1:0]   nwords;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [META_W-1:0]   meta_cnt;
   logic                grant, last_grant;

   logic                m_hs_c;
   logic                grant_nxt_c;
   logic                div_last_c;
   logic                data_last_c;
   logic                meta_last_c;
   logic [PS_W:0]       rem_shift_c;
   logic                rem_ge_c;
   logic [PS_W-1:0]     rem_nxt_c;
   logic [FS_W-1:0]     quo_nxt_c;

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   assign rem_shift_c = {rem_q, div_q[FS_W-1]};
   assign rem_ge_c    = (rem_shift_c >= {1'b0, packet_size_q});
   assign rem_nxt_c   = rem_ge_c ? PS_W'(rem_shift_c - {1'b0, packet_size_q}) : rem_shift_c[PS_W-1:0];
   assign quo_nxt_c   = {div_q[FS_W-2:0], rem_ge_c};
   assign div_last_c  = (div_cnt == DCNT_W'(DIV_STEPS - 1));

   assign grant_nxt_c = (s0_tvalid && s1_tvalid) ? ~last_grant : s1_tvalid;
   assign m_hs_c      = m_tvalid && m_tready;
   assign data_last_c = (beat_cnt == nwords - BEAT_W'(1));
   assign meta_last_c = (meta_cnt == META_W'(META_LEN - 1));

   assign m_tkeep = m_tvalid ? {KW{1'b1}} : '0;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and stream steering; payload paths are combinational for zero-latency pass-through.
   always_comb begin
      state_nxt = state;
      m_tdata   = '0;
      m_tvalid  = 1'b0;
      m_tlast   = 1'b0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
      sm_tready = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_load)                                   state_nxt = CALC;
            else if (enable && (nwords != '0) && !cfg_err)  state_nxt = WAIT_SRC;
         end
         CALC: begin
            if ((packet_size_q == '0) || div_last_c) state_nxt = IDLE;
         end
         WAIT_SRC: begin
            if (!enable)                     state_nxt = IDLE;
            else if (s0_tvalid || s1_tvalid) state_nxt = DATA;
         end
         DATA: begin
            if (grant) begin
               m_tdata   = s1_tdata;
               m_tvalid  = s1_tvalid;
               s1_tready = m_tready;
            end else begin
               m_tdata   = s0_tdata;
               m_tvalid  = s0_tvalid;
               s0_tready = m_tready;
            end
            if (m_tvalid && m_tready && data_last_c) state_nxt = META;
         end
         META: begin
            m_tdata   = sm_tdata;
            m_tvalid  = sm_tvalid;
            sm_tready = m_tready;
            if (m_tvalid && m_tready && meta_last_c) state_nxt = COUNT;
         end
         COUNT: begin
            m_tdata  = DW'(frame_count);
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            if (m_tready) state_nxt = enable ? WAIT_SRC : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Config latch, divider, arbitration bookkeeping and frame counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         packet_size_q <= '0;
         div_q         <= '0;
         rem_q         <= '0;
         div_cnt       <= '0;
         nwords        <= '0;
         cfg_err       <= 1'b0;
         beat_cnt      <= '0;
         meta_cnt      <= '0;
         grant         <= 1'b0;
         last_grant    <= 1'b1;
         frame_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_load) begin
                  packet_size_q <= cfg_packet_size;
                  div_q         <= cfg_frame_size;
                  rem_q         <= '0;
                  div_cnt       <= '0;
               end
            end
            CALC: begin
               if (packet_size_q == '0) begin
                  cfg_err <= 1'b1;
                  nwords  <= '0;
               end else begin
                  div_q   <= quo_nxt_c;
                  rem_q   <= rem_nxt_c;
                  div_cnt <= div_cnt + DCNT_W'(1);
                  if (div_last_c) begin
                     nwords  <= quo_nxt_c;
                     cfg_err <= (quo_nxt_c == '0);
                  end
               end
            end
            WAIT_SRC: begin
               if (enable && (s0_tvalid || s1_tvalid)) begin
                  grant    <= grant_nxt_c;
                  beat_cnt <= '0;
                  meta_cnt <= '0;
               end
            end
            DATA: begin
               if (m_hs_c) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
                  if (data_last_c) last_grant <= grant;
               end
            end
            META: begin
               if (m_hs_c) meta_cnt <= meta_cnt + META_W'(1);
            end
            COUNT: begin
               if (m_tready) frame_count <= frame_count + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pingpong_frame_scheduler.sv
// Scoreboard bench for pingpong_frame_scheduler: expected beats are queued from a small
// arbitration/frame model and matched against every output handshake.
`timescale 1ns/1ps
module tb_pingpong_frame_scheduler;

   localparam int unsigned DW       = 64;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned META_LEN = 2;
   localparam int unsigned KW       = DW / 8;
   localparam int          LIMIT    = 4000;

   logic             clk = 1'b0;
   logic             resetn = 1'b1;
   logic             enable = 1'b0;
   logic             cfg_load = 1'b0;
   logic [31:0]      cfg_frame_size = '0;
   logic [15:0]      cfg_packet_size = '0;
   logic             cfg_err;
   logic [DW-1:0]    s0_tdata, s1_tdata, sm_tdata;
   logic             s0_tvalid = 1'b0, s1_tvalid = 1'b0, sm_tvalid = 1'b1;
   logic             s0_tready, s1_tready, sm_tready;
   logic [DW-1:0]    m_tdata;
   logic             m_tvalid, m_tlast;
   logic             m_tready = 1'b1;
   logic [KW-1:0]    m_tkeep;
   logic [CNT_W-1:0] frame_count;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;
   int seq0 = 0, seq1 = 0, seqm = 0;
   int hs_total = 0, frames_seen = 0;
   bit rand_ready = 1'b0;

   // model state
   logic [DW:0] exp_q[$];
   int e0 = 0, e1 = 0, em = 0, ecnt = 0, nw = 0;
   bit last_g = 1'b1;

   assign s0_tdata = {32'h5300_0000, 32'(seq0)};
   assign s1_tdata = {32'h5311_0000, 32'(seq1)};
   assign sm_tdata = {32'h4D00_0000, 32'(seqm)};

   pingpong_frame_scheduler #(.DW(DW), .CNT_W(CNT_W), .META_LEN(META_LEN)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .cfg_load(cfg_load),
      .cfg_frame_size(cfg_frame_size), .cfg_packet_size(cfg_packet_size), .cfg_err(cfg_err),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
      .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .m_tkeep(m_tkeep), .frame_count(frame_count), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Source models: advance the sequence number after each accepted beat; optional random backpressure.
   initial begin : drv
      bit h0, h1, hm;
      forever begin
         @(negedge clk);
         h0 = s0_tvalid && s0_tready;
         h1 = s1_tvalid && s1_tready;
         hm = sm_tvalid && sm_tready;
         @(posedge clk); #1;
         if (h0) seq0++;
         if (h1) seq1++;
         if (hm) seqm++;
         if (rand_ready) m_tready = ($urandom_range(0, 99) >= 30);
      end
   end

   // Output monitor: scoreboard match, tkeep, stability under backpressure, exclusive readies.
   initial begin : mon
      bit          stall_q;
      logic [DW-1:0] stall_data;
      logic [DW:0] e;
      stall_q = 1'b0;
      stall_data = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q) begin
               n_checks++;
               if (!m_tvalid || m_tdata !== stall_data) begin
                  n_fail++;
                  $display("FAIL stable: tvalid=%b data=%h required tvalid=1 data=%h", m_tvalid, m_tdata, stall_data);
               end
            end
            if (m_tvalid) begin
               n_checks++;
               if (m_tkeep !== {KW{1'b1}}) begin
                  n_fail++;
                  $display("FAIL tkeep: got %h required all ones", m_tkeep);
               end
            end
            if (s0_tready || s1_tready || sm_tready) begin
               n_checks++;
               if ($countones({s0_tready, s1_tready, sm_tready}) > 1) begin
                  n_fail++;
                  $display("FAIL ready_onehot: s0=%b s1=%b sm=%b", s0_tready, s1_tready, sm_tready);
               end
            end
            if (m_tvalid && m_tready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL beat: unexpected beat last=%b data=%h", m_tlast, m_tdata);
               end else begin
                  e = exp_q.pop_front();
                  if ({m_tlast, m_tdata} !== e) begin
                     n_fail++;
                     $display("FAIL beat: got last=%b data=%h required last=%b data=%h",
                              m_tlast, m_tdata, e[DW], e[DW-1:0]);
                  end
               end
               hs_total++;
               if (m_tlast) frames_seen++;
            end
            stall_q    = m_tvalid && !m_tready;
            stall_data = m_tdata;
         end
      end
   end

   task automatic push_frame(input bit src);
      for (int i = 0; i < nw; i++) begin
         if (src) begin exp_q.push_back({1'b0, 32'h5311_0000, 32'(e1)}); e1++; end
         else     begin exp_q.push_back({1'b0, 32'h5300_0000, 32'(e0)}); e0++; end
      end
      for (int i = 0; i < META_LEN; i++) begin
         exp_q.push_back({1'b0, 32'h4D00_0000, 32'(em)});
         em++;
      end
      exp_q.push_back({1'b1, DW'(ecnt)});
      ecnt = (ecnt + 1) % (1 << CNT_W);
   endtask

   task automatic push_arb(input bit v0, input bit v1);
      bit g;
      g = (v0 && v1) ? !last_g : v1;
      last_g = g;
      push_frame(g);
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      enable = 1'b0; cfg_load = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      rand_ready = 1'b0; m_tready = 1'b1;
      repeat (3) @(posedge clk);
      exp_q.delete();
      seq0 = 0; seq1 = 0; seqm = 0;
      e0 = 0; e1 = 0; em = 0; ecnt = 0; last_g = 1'b1;
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic load_cfg(input logic [31:0] fs, input logic [15:0] ps, output int cyc);
      @(posedge clk); #1;
      cfg_frame_size = fs; cfg_packet_size = ps; cfg_load = 1'b1;
      @(posedge clk); #1;
      cfg_load = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         @(posedge clk); #1;
      end
   endtask

   // Enable exactly n frames: drop enable once the n-th frame has started moving data.
   task automatic run_frames(input int n);
      int start, snap, t;
      start = frames_seen; t = 0;
      enable = 1'b1;
      while (frames_seen < start + n - 1 && t < LIMIT) begin @(negedge clk); #1; t++; end
      snap = hs_total;
      while (hs_total == snap && t < LIMIT) begin @(negedge clk); #1; t++; end
      @(posedge clk); #1;
      enable = 1'b0;
      while ((frames_seen < start + n || busy) && t < LIMIT) begin @(negedge clk); #1; t++; end
      n_checks++;
      if (t >= LIMIT) begin
         n_fail++;
         $display("FAIL run_frames: %0d frames seen, required %0d", frames_seen - start, n);
      end
   endtask

   task automatic check_done(input string name, input int req_count);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      end
      n_checks++;
      if (frame_count !== CNT_W'(req_count)) begin
         n_fail++;
         $display("FAIL %s_count: frame_count=%0d required %0d", name, frame_count, req_count);
      end
   endtask

   task automatic test_reset();
      bit bad;
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if ({busy, cfg_err, m_tvalid, m_tlast, s0_tready, s1_tready, sm_tready} !== 7'b0 ||
          m_tdata !== '0 || frame_count !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b err=%b tvalid=%b tlast=%b rdy=%b%b%b data=%h cnt=%0d required all 0",
                  busy, cfg_err, m_tvalid, m_tlast, s0_tready, s1_tready, sm_tready, m_tdata, frame_count);
      end
      apply_reset();
      s0_tvalid = 1'b1; enable = 1'b1; bad = 1'b0;
      repeat (8) begin @(negedge clk); if (busy !== 1'b0) bad = 1'b1; end
      enable = 1'b0; s0_tvalid = 1'b0;
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL reset_nwords0: busy went 1 with nwords=0, required 0");
      end
   endtask

   task automatic test_cfg();
      int  c;
      bit  bad;
      apply_reset();
      load_cfg(32'd1000, 16'd0, c);
      n_checks++;
      if (c != 1 || cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_pkt0: calc_cycles=%0d err=%b required 1 and 1", c, cfg_err);
      end
      s0_tvalid = 1'b1; enable = 1'b1; bad = 1'b0;
      repeat (8) begin @(negedge clk); if (busy !== 1'b0) bad = 1'b1; end
      enable = 1'b0;
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL cfg_err_blocks: busy=1 with cfg_err set, required 0");
      end
      load_cfg(32'd10, 16'd64, c);
      n_checks++;
      if (c != 32 || cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_quo0: calc_cycles=%0d err=%b required 32 and 1", c, cfg_err);
      end
      load_cfg(32'd100, 16'd64, c);
      n_checks++;
      if (c != 32 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_100_64: calc_cycles=%0d err=%b required 32 and 0", c, cfg_err);
      end
      nw = 1;
      push_arb(1'b1, 1'b0);
      run_frames(1);
      check_done("cfg_100_64", 1);
      load_cfg(32'd1000, 16'd7, c);
      nw = 142;
      s0_tvalid = 1'b0; s1_tvalid = 1'b1;
      push_arb(1'b0, 1'b1);
      run_frames(1);
      s1_tvalid = 1'b0;
      check_done("cfg_1000_7", 2);
   endtask

   task automatic test_single_frame();
      int c;
      apply_reset();
      load_cfg(32'd1024, 16'd64, c);
      n_checks++;
      if (c != 32 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL single_cfg: calc_cycles=%0d err=%b required 32 and 0", c, cfg_err);
      end
      nw = 16;
      s0_tvalid = 1'b1;
      push_arb(1'b1, 1'b0);
      run_frames(1);
      s0_tvalid = 1'b0;
      check_done("single", 1);
   endtask

   task automatic test_back_to_back();
      int c;
      apply_reset();
      load_cfg(32'd128, 16'd64, c);
      nw = 2;
      s0_tvalid = 1'b1; s1_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) push_arb(1'b1, 1'b1);
      run_frames(4);
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      check_done("b2b", 4);
   endtask

   task automatic test_backpressure();
      int c;
      apply_reset();
      load_cfg(32'd192, 16'd64, c);
      nw = 3;
      s0_tvalid = 1'b1; s1_tvalid = 1'b1;
      rand_ready = 1'b1;
      for (int i = 0; i < 6; i++) push_arb(1'b1, 1'b1);
      run_frames(6);
      rand_ready = 1'b0;
      @(posedge clk); #1;
      m_tready = 1'b1;
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      check_done("bp", 6);
   endtask

   task automatic test_reset_mid_frame();
      int c, snap, t;
      bit bad;
      apply_reset();
      load_cfg(32'd1024, 16'd64, c);
      nw = 16;
      s0_tvalid = 1'b1;
      push_arb(1'b1, 1'b0);
      run_frames(1);
      check_done("midrst_pre", 1);
      push_arb(1'b1, 1'b0);
      snap = hs_total; t = 0;
      enable = 1'b1;
      while (hs_total < snap + 4 && t < LIMIT) begin @(negedge clk); #1; t++; end
      n_checks++;
      if (t >= LIMIT) begin
         n_fail++;
         $display("FAIL midrst_wait: %0d beats seen, required 4", hs_total - snap);
      end
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || s0_tready !== 1'b0 ||
          busy !== 1'b0 || frame_count !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: tvalid=%b tlast=%b data=%h s0_rdy=%b busy=%b cnt=%0d required all 0",
                  m_tvalid, m_tlast, m_tdata, s0_tready, busy, frame_count);
      end
      enable = 1'b0;
      exp_q.delete();
      @(negedge clk); resetn = 1'b1;
      enable = 1'b1; bad = 1'b0;
      repeat (6) begin @(negedge clk); if (busy !== 1'b0 || frame_count !== '0) bad = 1'b1; end
      enable = 1'b0; s0_tvalid = 1'b0;
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL midrst_after: busy=%b cnt=%0d required 0 and 0", busy, frame_count);
      end
   endtask

   task automatic test_wrap();
      int c;
      apply_reset();
      load_cfg(32'd64, 16'd64, c);
      nw = 1;
      s0_tvalid = 1'b1;
      for (int i = 0; i < (1 << CNT_W); i++) push_arb(1'b1, 1'b0);
      run_frames(1 << CNT_W);
      s0_tvalid = 1'b0;
      check_done("wrap", 0);
   endtask

   initial begin
      test_reset();
      test_cfg();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_frame();
      test_wrap();
      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
